// File: rtl/cpu_consts.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | cpu_consts: ALU function, opcode and funct encodings for decode/execute |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package cpu_consts;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SRL  = 4'b0011,
      ALU_SRA  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_AND  = 4'b0110,
      ALU_XOR  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SLT  = 4'b1001
   } alu_func_e;

   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;

   localparam logic [2:0] c_f3_add_sub = 3'b000;
   localparam logic [2:0] c_f3_sll     = 3'b001;
   localparam logic [2:0] c_f3_slt     = 3'b010;
   localparam logic [2:0] c_f3_sltu    = 3'b011;
   localparam logic [2:0] c_f3_xor     = 3'b100;
   localparam logic [2:0] c_f3_srl_sra = 3'b101;
   localparam logic [2:0] c_f3_or      = 3'b110;
   localparam logic [2:0] c_f3_and     = 3'b111;

   localparam logic [6:0] c_f7_base = 7'b0000000;
   localparam logic [6:0] c_f7_alt  = 7'b0100000;

   // RV64 immediate shifts reserve only instr[31:26]; instr[25] is shamt MSB.
   localparam logic [5:0] c_f6_srl = 6'b000000;
   localparam logic [5:0] c_f6_sra = 6'b010000;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | imm_gen: I-type and U-type immediates, sign-extended to 64 bits          |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module imm_gen (
   input  logic [31:0] instr_i,
   output logic [63:0] imm_i_o,
   output logic [63:0] imm_u_o
);

   assign imm_i_o = {{52{instr_i[31]}}, instr_i[31:20]};
   assign imm_u_o = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};

endmodule
`default_nettype wire

// File: rtl/decode.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | decode: integer ALU decode into a one-entry handshake pipeline register  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module decode
   import cpu_consts::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instr_i,
   input  logic [63:0] pc_i,
   output logic [4:0]  rs1_addr_o,
   output logic [4:0]  rs2_addr_o,
   input  logic [63:0] rs1_data_i,
   input  logic [63:0] rs2_data_i,
   input  logic        flush_i,
   output logic        dec_valid_o,
   input  logic        dec_ready_i,
   output logic [63:0] opr_a_o,
   output logic [63:0] opr_b_o,
   output logic [3:0]  alu_func_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_wr_en_o,
   output logic        illegal_o,
   output logic [63:0] pc_o
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic        w_accept;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rd;
   logic [63:0] w_imm_i;
   logic [63:0] w_imm_u;
   logic [63:0] w_shamt;

   logic [63:0] w_opr_a;
   logic [63:0] w_opr_b;
   alu_func_e   w_alu_func;
   logic        w_illegal;

   logic [63:0] r_opr_a;
   logic [63:0] r_opr_b;
   logic [3:0]  r_alu_func;
   logic [4:0]  r_rd_addr;
   logic        r_rd_wr_en;
   logic        r_illegal;
   logic [63:0] r_pc;

   assign w_opcode   = instr_i[6:0];
   assign w_rd       = instr_i[11:7];
   assign w_funct3   = instr_i[14:12];
   assign w_funct7   = instr_i[31:25];
   assign w_shamt    = {58'd0, instr_i[25:20]};
   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   imm_gen u_imm_gen (
      .instr_i (instr_i),
      .imm_i_o (w_imm_i),
      .imm_u_o (w_imm_u)
   );

   always_comb begin
      w_opr_a    = '0;
      w_opr_b    = '0;
      w_alu_func = ALU_ADD;
      w_illegal  = 1'b0;
      case (w_opcode)
         c_opc_op: begin
            w_opr_a = rs1_data_i;
            w_opr_b = rs2_data_i;
            if (w_funct7 == c_f7_base) begin
               case (w_funct3)
                  c_f3_add_sub: w_alu_func = ALU_ADD;
                  c_f3_sll:     w_alu_func = ALU_SLL;
                  c_f3_slt:     w_alu_func = ALU_SLT;
                  c_f3_sltu:    w_alu_func = ALU_SLTU;
                  c_f3_xor:     w_alu_func = ALU_XOR;
                  c_f3_srl_sra: w_alu_func = ALU_SRL;
                  c_f3_or:      w_alu_func = ALU_OR;
                  default:      w_alu_func = ALU_AND;
               endcase
            end else if (w_funct7 == c_f7_alt && w_funct3 == c_f3_add_sub) begin
               w_alu_func = ALU_SUB;
            end else if (w_funct7 == c_f7_alt && w_funct3 == c_f3_srl_sra) begin
               w_alu_func = ALU_SRA;
            end else begin
               w_illegal = 1'b1;
            end
         end
         c_opc_op_imm: begin
            w_opr_a = rs1_data_i;
            w_opr_b = w_imm_i;
            case (w_funct3)
               c_f3_add_sub: w_alu_func = ALU_ADD;
               c_f3_slt:     w_alu_func = ALU_SLT;
               c_f3_sltu:    w_alu_func = ALU_SLTU;
               c_f3_xor:     w_alu_func = ALU_XOR;
               c_f3_or:      w_alu_func = ALU_OR;
               c_f3_and:     w_alu_func = ALU_AND;
               c_f3_sll: begin
                  w_opr_b = w_shamt;
                  if (instr_i[31:26] == c_f6_srl) w_alu_func = ALU_SLL;
                  else                            w_illegal  = 1'b1;
               end
               default: begin
                  w_opr_b = w_shamt;
                  if (instr_i[31:26] == c_f6_srl)      w_alu_func = ALU_SRL;
                  else if (instr_i[31:26] == c_f6_sra) w_alu_func = ALU_SRA;
                  else                                 w_illegal  = 1'b1;
               end
            endcase
         end
         c_opc_lui: begin
            w_opr_b = w_imm_u;
         end
         c_opc_auipc: begin
            w_opr_a = pc_i;
            w_opr_b = w_imm_u;
         end
         default: w_illegal = 1'b1;
      endcase
      // Illegal instructions travel as an inert ADD of zeros.
      if (w_illegal) begin
         w_opr_a    = '0;
         w_opr_b    = '0;
         w_alu_func = ALU_ADD;
      end
   end

   assign dec_valid_o   = (r_state == ST_FULL);
   assign instr_ready_o = !dec_valid_o || dec_ready_i;
   assign w_accept      = instr_valid_i && instr_ready_o && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
         ST_FULL: begin
            if (w_accept)         w_state_nxt = ST_FULL;
            else if (dec_ready_i) w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush_i) w_state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_opr_a    <= '0;
         r_opr_b    <= '0;
         r_alu_func <= '0;
         r_rd_addr  <= '0;
         r_rd_wr_en <= 1'b0;
         r_illegal  <= 1'b0;
         r_pc       <= '0;
      end else if (w_accept) begin
         r_opr_a    <= w_opr_a;
         r_opr_b    <= w_opr_b;
         r_alu_func <= w_alu_func;
         r_rd_addr  <= w_rd;
         r_rd_wr_en <= !w_illegal && (w_rd != 5'd0);
         r_illegal  <= w_illegal;
         r_pc       <= pc_i;
      end
   end

   assign opr_a_o    = r_opr_a;
   assign opr_b_o    = r_opr_b;
   assign alu_func_o = r_alu_func;
   assign rd_addr_o  = r_rd_addr;
   assign rd_wr_en_o = r_rd_wr_en;
   assign illegal_o  = r_illegal;
   assign pc_o       = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_decode: scoreboard bench for decode                                   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, instr_ready;
   logic [31:0] instr;
   logic [63:0] pc_in;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [63:0] rs1_data, rs2_data;
   logic        flush;
   logic        dec_valid, dec_ready;
   logic [63:0] opr_a, opr_b, pc_out;
   logic [3:0]  alu_func;
   logic [4:0]  rd_addr;
   logic        rd_wr_en, illegal;

   typedef struct packed {
      logic        ill;
      logic        wr;
      logic [4:0]  rd;
      logic [3:0]  func;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] pc;
   } out_t;

   typedef struct {
      logic [31:0] ins;
      logic [63:0] r1;
      logic [63:0] r2;
      logic [63:0] pc;
      out_t        exp;
   } vec_t;

   out_t obs;
   out_t sb[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] UIMM = 64'hFFFF_FFFF_8000_0000;

   always #5 clk = ~clk;

   assign obs = {illegal, rd_wr_en, rd_addr, alu_func, opr_a, opr_b, pc_out};

   decode dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .instr_valid_i (instr_valid),
      .instr_ready_o (instr_ready),
      .instr_i       (instr),
      .pc_i          (pc_in),
      .rs1_addr_o    (rs1_addr),
      .rs2_addr_o    (rs2_addr),
      .rs1_data_i    (rs1_data),
      .rs2_data_i    (rs2_data),
      .flush_i       (flush),
      .dec_valid_o   (dec_valid),
      .dec_ready_i   (dec_ready),
      .opr_a_o       (opr_a),
      .opr_b_o       (opr_b),
      .alu_func_o    (alu_func),
      .rd_addr_o     (rd_addr),
      .rd_wr_en_o    (rd_wr_en),
      .illegal_o     (illegal),
      .pc_o          (pc_out)
   );

   function automatic out_t mk(input logic ill, input logic wr, input logic [4:0] rd,
                               input logic [3:0] f, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] pc);
      return {ill, wr, rd, f, a, b, pc};
   endfunction

   task automatic put(input vec_t v);
      instr_valid = 1'b1;
      instr       = v.ins;
      rs1_data    = v.r1;
      rs2_data    = v.r2;
      pc_in       = v.pc;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b0 || instr_ready !== 1'b1 || obs !== '0) begin
         errors++;
         $display("FAIL reset: valid=%b ready=%b got %h exp 0", dec_valid, instr_ready, obs);
      end
      rst = 1'b0;
   endtask

   task automatic test_op;
      vec_t v[10];
      out_t e;
      v = '{
         '{32'h002081B3, 64'd5,  64'd7, 64'h100, mk(0, 1, 3, 4'b0000, 64'd5,  64'd7, 64'h100)},
         '{32'h402081B3, 64'd10, 64'd3, 64'h104, mk(0, 1, 3, 4'b0001, 64'd10, 64'd3, 64'h104)},
         '{32'h002091B3, 64'd1,  64'd2, 64'h108, mk(0, 1, 3, 4'b0010, 64'd1,  64'd2, 64'h108)},
         '{32'h0020A1B3, 64'd3,  64'd4, 64'h10C, mk(0, 1, 3, 4'b1001, 64'd3,  64'd4, 64'h10C)},
         '{32'h0020B1B3, 64'd5,  64'd6, 64'h110, mk(0, 1, 3, 4'b1000, 64'd5,  64'd6, 64'h110)},
         '{32'h0020C1B3, 64'd7,  64'd8, 64'h114, mk(0, 1, 3, 4'b0111, 64'd7,  64'd8, 64'h114)},
         '{32'h0020D1B3, 64'd9,  64'd1, 64'h118, mk(0, 1, 3, 4'b0011, 64'd9,  64'd1, 64'h118)},
         '{32'h4020D1B3, 64'd11, 64'd2, 64'h11C, mk(0, 1, 3, 4'b0100, 64'd11, 64'd2, 64'h11C)},
         '{32'h0020E1B3, 64'd13, 64'd3, 64'h120, mk(0, 1, 3, 4'b0101, 64'd13, 64'd3, 64'h120)},
         '{32'h0020F1B3, 64'd15, 64'd4, 64'h124, mk(0, 1, 3, 4'b0110, 64'd15, 64'd4, 64'h124)}
      };
      dec_ready = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (dec_valid !== 1'b1 || obs !== e) begin
               errors++;
               $display("FAIL op[%0d]: valid=%b got %h exp %h", i - 1, dec_valid, obs, e);
            end
         end
         if (i < 10) begin
            put(v[i]);
            sb.push_back(v[i].exp);
         end else begin
            instr_valid = 1'b0;
         end
         if (i == 0) begin
            #1;
            checks++;
            if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
               errors++;
               $display("FAIL rs_addr: got %0d/%0d exp 1/2", rs1_addr, rs2_addr);
            end
         end
      end
   endtask

   task automatic test_op_imm;
      vec_t v[6];
      out_t e;
      v = '{
         '{32'h43F35293, 64'h8000_0000_0000_0000, 64'd0, 64'h200,
           mk(0, 1, 5, 4'b0100, 64'h8000_0000_0000_0000, 64'h3F, 64'h200)},
         '{32'hFFF00093, 64'd0,  64'd9, 64'h204, mk(0, 1, 1, 4'b0000, 64'd0,  ONES,      64'h204)},
         '{32'h00331293, 64'd1,  64'd9, 64'h208, mk(0, 1, 5, 4'b0010, 64'd1,  64'd3,     64'h208)},
         '{32'h00135293, 64'd8,  64'd9, 64'h20C, mk(0, 1, 5, 4'b0011, 64'd8,  64'd1,     64'h20C)},
         '{32'hFFF33293, 64'd4,  64'd9, 64'h210, mk(0, 1, 5, 4'b1000, 64'd4,  ONES,      64'h210)},
         '{32'h7FF37293, 64'd6,  64'd9, 64'h214, mk(0, 1, 5, 4'b0110, 64'd6,  64'h7FF,   64'h214)}
      };
      dec_ready = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (dec_valid !== 1'b1 || obs !== e) begin
               errors++;
               $display("FAIL op_imm[%0d]: valid=%b got %h exp %h", i - 1, dec_valid, obs, e);
            end
         end
         if (i < 6) begin
            put(v[i]);
            sb.push_back(v[i].exp);
         end else begin
            instr_valid = 1'b0;
         end
      end
   endtask

   task automatic test_upper;
      vec_t v[2];
      out_t e;
      v = '{
         '{32'h80000137, 64'd77, 64'd88, 64'h2000, mk(0, 1, 2, 4'b0000, 64'd0,    UIMM, 64'h2000)},
         '{32'h80000117, 64'd77, 64'd88, 64'h1000, mk(0, 1, 2, 4'b0000, 64'h1000, UIMM, 64'h1000)}
      };
      dec_ready = 1'b1;
      for (int i = 0; i <= 2; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (dec_valid !== 1'b1 || obs !== e) begin
               errors++;
               $display("FAIL upper[%0d]: valid=%b got %h exp %h", i - 1, dec_valid, obs, e);
            end
         end
         if (i < 2) begin
            put(v[i]);
            sb.push_back(v[i].exp);
         end else begin
            instr_valid = 1'b0;
         end
      end
   endtask

   task automatic test_illegal;
      vec_t v[5];
      out_t e;
      v = '{
         '{32'h00000000, 64'd5, 64'd7, 64'h300, mk(1, 0, 0, 4'b0000, 64'd0, 64'd0, 64'h300)},
         '{32'h022081B3, 64'd5, 64'd7, 64'h304, mk(1, 0, 3, 4'b0000, 64'd0, 64'd0, 64'h304)},
         '{32'h402091B3, 64'd5, 64'd7, 64'h308, mk(1, 0, 3, 4'b0000, 64'd0, 64'd0, 64'h308)},
         '{32'h04331293, 64'd5, 64'd7, 64'h30C, mk(1, 0, 5, 4'b0000, 64'd0, 64'd0, 64'h30C)},
         '{32'h00208033, 64'd5, 64'd7, 64'h310, mk(0, 0, 0, 4'b0000, 64'd5, 64'd7, 64'h310)}
      };
      dec_ready = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (dec_valid !== 1'b1 || obs !== e) begin
               errors++;
               $display("FAIL illegal[%0d]: valid=%b got %h exp %h", i - 1, dec_valid, obs, e);
            end
         end
         if (i < 5) begin
            put(v[i]);
            sb.push_back(v[i].exp);
         end else begin
            instr_valid = 1'b0;
         end
      end
   endtask

   task automatic test_stall;
      vec_t a, b;
      out_t e;
      a = '{32'h002081B3, 64'd21, 64'd22, 64'h400, mk(0, 1, 3, 4'b0000, 64'd21, 64'd22, 64'h400)};
      b = '{32'h402081B3, 64'd31, 64'd32, 64'h404, mk(0, 1, 3, 4'b0001, 64'd31, 64'd32, 64'h404)};
      @(negedge clk);
      dec_ready = 1'b0;
      put(a);
      sb.push_back(a.exp);
      @(negedge clk);
      put(b);
      sb.push_back(b.exp);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dec_valid !== 1'b1 || instr_ready !== 1'b0 || obs !== sb[0]) begin
            errors++;
            $display("FAIL stall[%0d]: valid=%b ready=%b got %h exp %h",
                     k, dec_valid, instr_ready, obs, sb[0]);
         end
         @(negedge clk);
      end
      dec_ready = 1'b1;
      #1;
      e = sb.pop_front();
      checks++;
      if (instr_ready !== 1'b1 || dec_valid !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL release: ready=%b valid=%b got %h exp %h", instr_ready, dec_valid, obs, e);
      end
      @(negedge clk);
      instr_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (dec_valid !== 1'b1 || obs !== e) begin
         errors++;
         $display("FAIL after_release: valid=%b got %h exp %h", dec_valid, obs, e);
      end
      @(negedge clk);
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: valid=%b exp 0", dec_valid);
      end
   endtask

   task automatic test_flush;
      vec_t x;
      x = '{32'h002081B3, 64'd1, 64'd2, 64'h500, mk(0, 1, 3, 4'b0000, 64'd1, 64'd2, 64'h500)};
      @(negedge clk);
      dec_ready = 1'b1;
      put(x);
      flush = 1'b1;
      @(negedge clk);
      flush       = 1'b0;
      instr_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_accept: valid=%b exp 0", dec_valid);
      end
      dec_ready = 1'b0;
      put(x);
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_setup: valid=%b exp 1", dec_valid);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (dec_valid !== 1'b0 || instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_held: valid=%b ready=%b exp 0/1", dec_valid, instr_ready);
      end
      dec_ready = 1'b1;
   endtask

   task automatic test_async_reset;
      vec_t z;
      z = '{32'h00208033, 64'd3, 64'd4, 64'h600, mk(0, 0, 0, 4'b0000, 64'd3, 64'd4, 64'h600)};
      @(negedge clk);
      dec_ready = 1'b0;
      put(z);
      sb.push_back(z.exp);
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b1 || obs !== sb[0]) begin
         errors++;
         $display("FAIL pre_reset: valid=%b got %h exp %h", dec_valid, obs, sb[0]);
      end
      #2 rst = 1'b1;
      #1;
      sb.delete();
      checks++;
      if (dec_valid !== 1'b0 || instr_ready !== 1'b1 || obs !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b ready=%b got %h exp 0", dec_valid, instr_ready, obs);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (instr_ready !== 1'b1 || dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: ready=%b valid=%b exp 1/0", instr_ready, dec_valid);
      end
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      pc_in       = '0;
      rs1_data    = '0;
      rs2_data    = '0;
      flush       = 1'b0;
      dec_ready   = 1'b1;
      test_reset();
      test_op();
      test_op_imm();
      test_upper();
      test_illegal();
      test_stall();
      test_flush();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: got %0d entries exp 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst_i  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: instr_valid_i in 1, instr_ready_o out 1, instr_i in 32, pc_i in 64 (upstream handshake and instruction).
REQ-004 SHALL have ports: rs1_addr_o out 5, rs2_addr_o out 5 (combinational from instr_i[19:15], [24:20]); rs1_data_i in 64, rs2_data_i in 64 (same-cycle register-file read data).
REQ-005 SHALL have port: flush_i  in  1  discard held and incoming instruction.
REQ-006 SHALL have ports: dec_valid_o out 1, dec_ready_i in 1 (downstream handshake toward execute).
REQ-007 SHALL have ports: opr_a_o out 64, opr_b_o out 64, alu_func_o out 4, rd_addr_o out 5, rd_wr_en_o out 1, illegal_o out 1, pc_o out 64.

Function
REQ-008 SHALL use alu_func encoding ADD 0000, SUB 0001, SLL 0010, SRL 0011, SRA 0100, OR 0101, AND 0110, XOR 0111, SLTU 1000, SLT 1001.
REQ-009 SHALL be a one-entry pipeline register with states EMPTY (dec_valid_o=0) and FULL (dec_valid_o=1).
REQ-010 SHALL drive instr_ready_o = !dec_valid_o || dec_ready_i, combinationally.
REQ-011 SHALL capture decoded fields on instr_valid_i && instr_ready_o && !flush_i and present them the next cycle (latency 1).
REQ-012 SHALL go FULL->EMPTY on dec_ready_i without a new accept; FULL->FULL on simultaneous drain and accept.
REQ-013 SHALL hold all outputs bit-stable while dec_valid_o && !dec_ready_i.
REQ-014 SHALL, on flush_i, clear dec_valid_o next cycle; flush beats a same-cycle accept, which is dropped.
REQ-015 SHALL decode OP (0110011): opr_a=rs1_data, opr_b=rs2_data; funct3/funct7 to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; other funct7 illegal.
REQ-016 SHALL decode OP-IMM (0010011): opr_a=rs1_data, opr_b=sign-extended instr[31:20]; SLLI/SRLI need instr[31:26]=000000, SRAI 010000; shifts use opr_b = zero-extended instr[25:20].
REQ-017 SHALL decode LUI: opr_a=0, opr_b=sign-extended {instr[31:12],12'h0}, ADD; AUIPC: opr_a=pc_i, same opr_b, ADD.
REQ-018 SHALL flag every other opcode/funct combination illegal: illegal_o=1, rd_wr_en_o=0, alu_func ADD, opr_a/opr_b zero; dec_valid_o still asserts.
REQ-019 SHALL drive rd_wr_en_o = legal && rd != 0; rd_addr_o = instr[11:7]; pc_o = captured pc_i.

Reset
REQ-020 SHALL on rst_i asynchronously force EMPTY and zero all registered outputs (illegal_o=0, rd_wr_en_o=0).
REQ-021 SHALL drop a held instruction when reset asserts mid-stall; instr_ready_o=1 after release.

Structure
REQ-022 SHALL take alu_func enum, opcode and funct constants from shared package cpu_consts, also used by execute.
REQ-023 SHALL place immediate generation in combinational sub-module imm_gen (I/U types, 64-bit sign extension).

Verification
REQ-024 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle dec_valid_o=1, opr_a=5, opr_b=7, alu_func=0000, rd=3, rd_wr_en=1.
REQ-025 SRAI x5,x6,63 (0x43F35293) -> opr_b=0x3F, alu_func=0100; ADDI x1,x0,-1 (0xFFF00093) -> opr_b=0xFFFF_FFFF_FFFF_FFFF.
REQ-026 LUI x2,0x80000 (0x80000137) -> opr_a=0, opr_b=0xFFFF_FFFF_8000_0000; AUIPC same imm, pc=0x1000 -> opr_a=0x1000.
REQ-027 Hold dec_ready_i=0 3 cycles while FULL -> outputs stable, instr_ready_o=0; release -> next instruction accepted same cycle.
REQ-028 instr 0x0000_0000 -> illegal_o=1, rd_wr_en_o=0; ADD x0,x1,x2 -> rd_wr_en_o=0.
REQ-029 flush_i with accept -> dec_valid_o=0 next cycle; rst_i mid-stall -> dec_valid_o=0 immediately, without a clock edge.
